// File: rtl/ram_dp_clr_pkg.sv
// Shared types and defaults for the dual-read scratch RAM with hardware clear.
package ram_pkg;
  typedef enum logic {RAM_IDLE, RAM_CLEAR} ram_state_t;

  localparam int RAM_DEF_WIDTH = 8;
  localparam int RAM_DEF_DEPTH = 32;
endpackage

// File: rtl/ram_dp_clr_clear_fsm.sv
// Clear sweep engine: walks a pointer over every location after reset or on request.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter  int DEPTH  = RAM_DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_ptr;

  // A request arriving mid-sweep is ignored; only reset restarts the pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RAM_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        RAM_IDLE: begin
          if (clr_req) begin
            state   <= RAM_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        RAM_CLEAR: begin
          if (clr_ptr == LAST) begin
            state <= RAM_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          state <= RAM_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = clr_ptr;
endmodule

// File: rtl/ram_dp_clr.sv
// Scratch RAM: one write/async-read port, one async-read port, hardware clear.
// Optional same-cycle write forwarding on both read ports when RAM_WR_FWD_EN is defined.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter  int WIDTH  = RAM_DEF_WIDTH,
  parameter  int DEPTH  = RAM_DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              busy,
  output logic              wr_drop
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              a_ok;
  logic              wr_ok;

  ram_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write lands only in IDLE, outside a clear request, in range, and not on a reset edge.
  assign a_ok  = {1'b0, addr_a} < DEPTH_W;
  assign wr_ok = rst_n && we && !busy && !clr_req && a_ok;

  always_ff @(posedge clk) begin
    if (rst_n && clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[addr_a] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= we && !wr_ok;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  assign rd_addr[0] = addr_a;
  assign rd_addr[1] = addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic             in_range;
    logic [WIDTH-1:0] raw;

    assign in_range = {1'b0, rd_addr[gi]} < DEPTH_W;
`ifdef RAM_WR_FWD_EN
    logic fwd;
    assign fwd = wr_ok && (rd_addr[gi] == addr_a);
    assign raw = fwd ? data_in : mem[rd_addr[gi]];
`else
    assign raw = mem[rd_addr[gi]];
`endif
    // Masking during a sweep hides locations the pointer has not reached yet.
    assign rd_data[gi] = (busy || !in_range) ? '0 : raw;
  end

  assign data_out_a = rd_data[0];
  assign data_out_b = rd_data[1];
endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench: DEPTH=32 and DEPTH=20 instances driven by the same directed stimulus.
module tb_ram_dp_clr;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr_req = 1'b0;
  logic            we = 1'b0;
  logic [4:0]      addr_a = '0;
  logic [4:0]      addr_b = '0;
  logic [W-1:0]    data_in = '0;
  logic [1:0][W-1:0] oa, ob;
  logic [1:0]      bz, wd;

  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.WIDTH(W), .DEPTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .we(we), .addr_a(addr_a),
    .data_in(data_in), .data_out_a(oa[0]), .addr_b(addr_b), .data_out_b(ob[0]),
    .busy(bz[0]), .wr_drop(wd[0])
  );

  ram_dp_clr #(.WIDTH(W), .DEPTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .we(we), .addr_a(addr_a),
    .data_in(data_in), .data_out_a(oa[1]), .addr_b(addr_b), .data_out_b(ob[1]),
    .busy(bz[1]), .wr_drop(wd[1])
  );

`ifdef RAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a clear zeroes the whole array at once and counts down the busy cycles;
  // reads are masked while busy, so the progressive sweep is not observable.
  int         dep [2] = '{32, 20};
  int         left [2];
  bit         drop [2];
  logic [W-1:0] mem_m [2][32];
  bit         model_valid = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        left[k] = dep[k];
        for (int j = 0; j < 32; j++) mem_m[k][j] = '0;
        drop[k] = 0;
      end else if (left[k] > 0) begin
        left[k] = left[k] - 1;
        drop[k] = we;
      end else if (clr_req) begin
        left[k] = dep[k];
        for (int j = 0; j < 32; j++) mem_m[k][j] = '0;
        drop[k] = we;
      end else if (we && int'(addr_a) < dep[k]) begin
        mem_m[k][addr_a] = data_in;
        drop[k] = 0;
      end else begin
        drop[k] = we;
      end
    end
    model_valid = 1;
  end

  function automatic logic [W-1:0] exp_rd(input int k, input logic [4:0] addr);
    if (left[k] > 0 || int'(addr) >= dep[k]) return '0;
    if (FWD && rst_n && we && !clr_req && int'(addr_a) < dep[k] && addr == addr_a)
      return data_in;
    return mem_m[k][addr];
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(left[k] > 0));
        chk($sformatf("wr_drop[%0d]", k), 32'(wd[k]), 32'(drop[k]));
        chk($sformatf("out_a[%0d] addr=%0d", k, addr_a), 32'(oa[k]), 32'(exp_rd(k, addr_a)));
        chk($sformatf("out_b[%0d] addr=%0d", k, addr_b), 32'(ob[k]), 32'(exp_rd(k, addr_b)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(input int cycles, input int exp32, input int exp20, input string name);
    int c32, c20;
    c32 = 0;
    c20 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bz[0]) c32++;
      if (bz[1]) c20++;
      tick();
    end
    chk({name, "_len32"}, 32'(c32), 32'(exp32));
    chk({name, "_len20"}, 32'(c20), 32'(exp20));
  endtask

  logic [4:0]   wa_tab [6] = '{5'd0, 5'd19, 5'd20, 5'd31, 5'd12, 5'd12};
  logic [W-1:0] wd_tab [6] = '{8'h01, 8'h9E, 8'h55, 8'hC3, 8'h40, 8'h41};

  initial begin
    // Reset held for two edges, then busy length and an all-zero read sweep.
    tick();
    tick();
    rst_n = 1'b1;
    count_busy(40, 32, 20, "reset_sweep");
    for (int a = 0; a < 32; a++) begin
      addr_a = 5'(a);
      addr_b = 5'(31 - a);
      @(negedge clk);
      chk("zero_a32", 32'(oa[0]), 32'h0);
      chk("zero_b32", 32'(ob[0]), 32'h0);
      tick();
    end

    // Two writes then simultaneous reads on both ports.
    we = 1'b1; addr_a = 5'd3;  data_in = 8'hA5;
    tick();
    addr_a = 5'd31; data_in = 8'h3C;
    tick();
    we = 1'b0; addr_a = 5'd3; addr_b = 5'd31;
    @(negedge clk);
    chk("wr_rd_a32", 32'(oa[0]), 32'hA5);
    chk("wr_rd_b32", 32'(ob[0]), 32'h3C);
    chk("wr_rd_a20", 32'(oa[1]), 32'hA5);
    chk("oor_b20_31", 32'(ob[1]), 32'h0);
    chk("oor_drop20_31", 32'(wd[1]), 32'h1);
    chk("inrange_nodrop32", 32'(wd[0]), 32'h0);

    // Out-of-range write on the DEPTH=20 instance.
    tick();
    we = 1'b1; addr_a = 5'd25; data_in = 8'h77; addr_b = 5'd25;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("oor_drop20", 32'(wd[1]), 32'h1);
    chk("oor_b20_25", 32'(ob[1]), 32'h0);
    chk("inrange_b32_25", 32'(ob[0]), 32'h77);

    // Forwarding: same-cycle view of a write to the read addresses.
    tick();
    we = 1'b1; addr_a = 5'd7; data_in = 8'h11;
    tick();
    data_in = 8'h22; addr_b = 5'd7;
    @(negedge clk);
    chk("fwd_a32", 32'(oa[0]), FWD ? 32'h22 : 32'h11);
    chk("fwd_b32", 32'(ob[0]), FWD ? 32'h22 : 32'h11);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("post_a32", 32'(oa[0]), 32'h22);
    chk("post_b32", 32'(ob[0]), 32'h22);

    // Clear request with a colliding write; a later request must not extend the sweep.
    tick();
    clr_req = 1'b1; we = 1'b1; addr_a = 5'd5; data_in = 8'hFF; addr_b = 5'd3;
    begin
      int c32, c20;
      c32 = 0;
      c20 = 0;
      for (int i = 0; i < 45; i++) begin
        tick();
        clr_req = (i >= 10 && i < 13);
        we = 1'b0;
        @(negedge clk);
        if (bz[0]) c32++;
        if (bz[1]) c20++;
        if (i == 0) begin
          chk("clr_busy32", 32'(bz[0]), 32'h1);
          chk("clr_drop32", 32'(wd[0]), 32'h1);
          chk("clr_mask_b32", 32'(ob[0]), 32'h0);
        end
      end
      chk("clr_len32", 32'(c32), 32'd32);
      chk("clr_len20", 32'(c20), 32'd20);
    end
    tick();
    clr_req = 1'b0;
    @(negedge clk);
    chk("cleared_a32_5", 32'(oa[0]), 32'h0);
    chk("cleared_b32_3", 32'(ob[0]), 32'h0);

    // Reset ten cycles into a sweep restarts it from the first location.
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(45, 32, 20, "midsweep_reset");

    // Mixed writes, reading back the previous address on port B.
    for (int i = 0; i < 6; i++) begin
      we = 1'b1;
      addr_a = wa_tab[i];
      data_in = wd_tab[i];
      addr_b = (i == 0) ? 5'd0 : wa_tab[i-1];
      tick();
    end
    we = 1'b0;
    addr_a = 5'd12;
    addr_b = 5'd19;
    @(negedge clk);
    chk("last_wr_a32_12", 32'(oa[0]), 32'h41);
    chk("wr_b20_19", 32'(ob[1]), 32'h9E);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised successor to the processor's 32x8 scratch RAM.
- One synchronous write/async-read port (A) plus a second async-read port (B), so the datapath can read two operands in one cycle.
- Hardware clear engine zeroes every location after reset or on request, and reports busy while sweeping.
- Sits between the register/ALU datapath and the control unit.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of words (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
clr_req  in  1  request a full clear sweep (level, sampled on posedge)
we  in  1  write enable for port A
addr_a  in  ADDR_W  port A address (write and read)
data_in  in  WIDTH  port A write data
data_out_a  out  WIDTH  port A async read data
addr_b  in  ADDR_W  port B read address
data_out_b  out  WIDTH  port B async read data
busy  out  1  clear sweep in progress
wr_drop  out  1  one-cycle pulse: previous cycle's write was discarded

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low.
- FSM states are IDLE and CLEAR. Clear pointer clr_ptr is ADDR_W bits.
- Reset: posedge with rst_n=0 sets state to CLEAR, clr_ptr to 0 and wr_drop to 0. busy=1 from that edge. No array write occurs on a reset edge.
- CLEAR operation:
  - Each posedge with rst_n=1 writes 0 to mem[clr_ptr].
  - If clr_ptr==DEPTH-1, go to IDLE; otherwise clr_ptr+1.
  - busy is high for exactly DEPTH cycles after entering CLEAR.
- IDLE + clr_req=1 at posedge: go to CLEAR with clr_ptr=0. Any we in that same cycle is dropped; clear wins.
- CLEAR + clr_req: ignored. The sweep does not restart.
- Reset mid-sweep: the sweep restarts from 0.
- busy is a registered output: busy = (state==CLEAR).
- Write: in IDLE with no clr_req, we=1 and addr_a<DEPTH writes data_in to mem[addr_a] at posedge. Latency 1 cycle.
- Dropped write: we=1 while busy, or in the clr_req cycle, or with addr_a>=DEPTH, is discarded. wr_drop=1 for the following cycle only.
- Reads: combinational from the array; no clock latency.
  - The port outputs data, not the pointer: data_out_a = mem[addr_a], data_out_b = mem[addr_b].
  - Either output is 0 when busy=1 or when its address is >=DEPTH.
- Same-cycle read/write to the same address: reads return the old contents until the edge (without the optional feature).
- Reads during a sweep are masked to 0, so contents not yet cleared are never exposed.
- Writes to addr_a==addr_b are legal; both ports see the new value after the edge.

Optional Feature:
- Macro: RAM_WR_FWD_EN.
- Defined: adds write-forwarding. When we=1, the write is not dropped, and addr_x==addr_a, data_out_x = data_in in the same cycle. This applies to port A and port B.
- Undefined: no forwarding; old contents are returned until the edge. No extra muxing.
- Busy masking takes priority over forwarding in both builds.

Decomposition:
- Package ram_pkg:
  - typedef enum logic {RAM_IDLE, RAM_CLEAR} ram_state_t
  - RAM_DEF_WIDTH=8, RAM_DEF_DEPTH=32
- One sub-module, ram_clear_fsm:
  - Owns state, clr_ptr, busy and the clear-write strobe/address.
  - The top muxes clear writes over user writes and handles read masking, forwarding and wr_drop.

Test Plan:
- Reset sweep: DEPTH=32, rst_n low 2 cycles then high → busy high exactly 32 cycles after release. Afterwards every address reads 0 on both ports.
- Write/read: write 0xA5 to addr 3, then 0x3C to addr 31; set addr_a=3, addr_b=31 → data_out_a=0xA5, data_out_b=0x3C combinationally.
- Blocked write: clr_req and we=1 (addr 5, 0xFF) in the same IDLE cycle → busy=1, wr_drop=1 next cycle. After the sweep, mem[5]=0 and all reads are 0 while busy.
- Mid-sweep reset: pulse rst_n low at sweep cycle 10 → busy stays high 32 more cycles after release. clr_req asserted mid-sweep does not extend busy.
- Out-of-range: DEPTH=20, we=1 at addr 25 → wr_drop pulse, no location changed. addr_b=25 reads 0.
- Forwarding (RAM_WR_FWD_EN on/off): mem[7]=0x11; we=1, addr_a=addr_b=7, data_in=0x22 → with macro, both outputs read 0x22 before the edge; without macro, 0x11. After the edge both builds read 0x22.
